// File: rtl/mode_pkg.sv
// Shared types for the front-panel mode stepper: mode width, step FSM states
// and step-direction encoding.
package mode_pkg;

    localparam int unsigned MODE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } step_state_e;

    typedef enum logic [1:0] {
        NONE,
        UP,
        DOWN
    } step_dir_e;

    // Coinciding up and down steps cancel each other.
    function automatic step_dir_e step_dir(input logic up, input logic down);
        step_dir_e dir;
        dir = NONE;
        if (up && !down) begin
            dir = UP;
        end else if (down && !up) begin
            dir = DOWN;
        end
        return dir;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button: two-flop synchroniser, debouncer and hold/auto-repeat step
// FSM producing a one-cycle step pulse.
module btn_conditioner
    import mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic step
);

    localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    // Timers count down to zero, so loading N-1 spaces steps exactly N cycles apart.
    localparam logic [TMR_W-1:0] HOLD_LOAD   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LOAD = TMR_W'(REPEAT_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              clean_q, clean_d;
    logic [DEB_W-1:0]  deb_q, deb_d;
    step_state_e       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              step_q, step_d;

    // Synchroniser and debouncer: the clean level follows s2 after a stable run.
    always_comb begin
        s1_d    = btn_raw;
        s2_d    = s1_q;
        clean_d = clean_q;
        deb_d   = '0;
        if (s2_q != clean_q) begin
            if (deb_q == DEB_LAST) begin
                clean_d = ~clean_q;
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
        end
    end

    // Step FSM reacts to the clean level as it toggles, so the step lands one cycle later.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        step_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clean_d && !clean_q) begin
                    step_d  = 1'b1;
                    tmr_d   = HOLD_LOAD;
                    state_d = HOLD;
                end
            end
            HOLD, REPEAT: begin
                if (!clean_d) begin
                    state_d = IDLE;
                end else if (tmr_q == '0) begin
                    step_d  = 1'b1;
                    tmr_d   = REPEAT_LOAD;
                    state_d = REPEAT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            clean_q <= 1'b0;
            deb_q   <= '0;
            state_q <= IDLE;
            tmr_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            clean_q <= clean_d;
            deb_q   <= deb_d;
            state_q <= state_d;
            tmr_q   <= tmr_d;
            step_q  <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/mode_stepper.sv
// Front-panel mode selector: two conditioned buttons step a wrap-around mode
// code for the mode decoder, with a one-cycle change strobe.
module mode_stepper
    import mode_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned REPEAT_CYCLES   = 32,
    parameter int unsigned MODE_MAX        = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    output logic [MODE_W-1:0] mode_d,
    output logic              mode_chg
);

    localparam logic [MODE_W-1:0] MODE_TOP = MODE_W'(MODE_MAX);

    logic              step_up;
    logic              step_down;
    step_dir_e         dir;
    logic [MODE_W-1:0] mode_reg_q, mode_reg_d;
    logic              chg_q, chg_d;

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .step    (step_up)
    );

    btn_conditioner #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_down),
        .step    (step_down)
    );

    assign dir = step_dir(step_up, step_down);

    // Wrap is decided by comparing against MODE_TOP, never by register overflow.
    always_comb begin
        mode_reg_d = mode_reg_q;
        chg_d      = 1'b0;
        case (dir)
            UP: begin
                mode_reg_d = (mode_reg_q >= MODE_TOP) ? '0 : mode_reg_q + MODE_W'(1);
                chg_d      = 1'b1;
            end
            DOWN: begin
                mode_reg_d = (mode_reg_q == '0) ? MODE_TOP : mode_reg_q - MODE_W'(1);
                chg_d      = 1'b1;
            end
            default: begin
                mode_reg_d = mode_reg_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_reg_q <= '0;
            chg_q      <= 1'b0;
        end else begin
            mode_reg_q <= mode_reg_d;
            chg_q      <= chg_d;
        end
    end

    assign mode_d   = mode_reg_q;
    assign mode_chg = chg_q;

endmodule

// File: tb/tb_mode_stepper.sv
// Scoreboard bench for mode_stepper: stimulus pushes expected (mode, edge)
// pairs, a negedge monitor pops and compares on every mode_chg strobe.
module tb_mode_stepper;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 8;
    localparam int unsigned MMAX = 9;
    // Raw edge driven before edge E0 shows up on mode_d at E0+DEB+2.
    localparam int LAT = int'(DEB) + 3;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] mode_d;
    logic       mode_chg;

    int ecnt = 0;
    int n_checks = 0;
    int n_pass = 0;
    int exp_mode = 0;
    int exp_mode_q[$];
    int exp_cyc_q[$];

    mode_stepper #(
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .REPEAT_CYCLES   (REP),
        .MODE_MAX        (MMAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .mode_d   (mode_d),
        .mode_chg (mode_chg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    function automatic int m_up(input int m);
        return (m == int'(MMAX)) ? 0 : m + 1;
    endfunction

    function automatic int m_down(input int m);
        return (m == 0) ? int'(MMAX) : m - 1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int m, input int cyc);
        exp_mode_q.push_back(m);
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic press_up(input int hold);
        btn_up = 1'b1;
        exp_mode = m_up(exp_mode);
        expect_at(exp_mode, ecnt + LAT);
        tick(hold);
        btn_up = 1'b0;
        tick(12);
    endtask

    task automatic press_down(input int hold);
        btn_down = 1'b1;
        exp_mode = m_down(exp_mode);
        expect_at(exp_mode, ecnt + LAT);
        tick(hold);
        btn_down = 1'b0;
        tick(12);
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        tick(2);
        check({name, "_mode"}, int'(mode_d), 0);
        check({name, "_chg"}, int'(mode_chg), 0);
        rst = 1'b0;
        exp_mode = 0;
    endtask

    // Monitor: every strobe must match the head of the scoreboard; overdue entries are misses.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (mode_chg === 1'b1) begin
                if (exp_mode_q.size() == 0) begin
                    check("unexpected_chg_pending", 0, 1);
                end else begin
                    check("chg_mode", int'(mode_d), exp_mode_q.pop_front());
                    check("chg_edge", ecnt, exp_cyc_q.pop_front());
                end
            end else if (exp_cyc_q.size() > 0 && ecnt >= exp_cyc_q[0]) begin
                check("missed_chg_edge", ecnt + 1000, exp_cyc_q[0]);
                void'(exp_mode_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        do_reset("reset");

        // Clean press: 0 -> 1.
        press_up(8);

        // Bounce burst ending low, then the same burst ending high.
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; tick(2);
            btn_up = 1'b0; tick(2);
        end
        tick(12);
        check("bounce_low_mode", int'(mode_d), exp_mode);
        for (int i = 0; i < 5; i++) begin
            btn_up = 1'b1; tick(2);
            btn_up = 1'b0; tick(2);
        end
        press_up(8);
        check("bounce_high_mode", int'(mode_d), 2);

        // Wrap in both directions.
        do_reset("wrap_reset");
        for (int i = 0; i < 10; i++) press_up(8);
        check("wrap_up_mode", int'(mode_d), 0);
        press_down(8);
        check("wrap_down_mode", int'(mode_d), 9);

        // Auto-repeat: steps at +0, +20, +28, +36, +44, release before the next one.
        do_reset("repeat_reset");
        btn_up = 1'b1;
        k = ecnt;
        expect_at(1, k + LAT);
        expect_at(2, k + LAT + 20);
        expect_at(3, k + LAT + 28);
        expect_at(4, k + LAT + 36);
        expect_at(5, k + LAT + 44);
        exp_mode = 5;
        tick(48);
        btn_up = 1'b0;
        tick(15);
        check("repeat_mode", int'(mode_d), 5);

        // Simultaneous rise cancels.
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(8);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(15);
        check("simul_cancel_mode", int'(mode_d), 5);

        // Up then down three cycles later: +1 then -1.
        btn_up = 1'b1;
        k = ecnt;
        expect_at(6, k + LAT);
        tick(3);
        btn_down = 1'b1;
        expect_at(5, k + 3 + LAT);
        tick(8);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(15);
        check("staggered_mode", int'(mode_d), 5);

        // Reset while HOLD is running at mode 7, button kept pressed through reset.
        press_up(8);
        btn_up = 1'b1;
        exp_mode = m_up(exp_mode);
        expect_at(exp_mode, ecnt + LAT);
        tick(12);
        check("pre_midrst_mode", int'(mode_d), 7);
        rst = 1'b1;
        tick(1);
        check("midrst_mode", int'(mode_d), 0);
        check("midrst_chg", int'(mode_chg), 0);
        rst = 1'b0;
        exp_mode = 1;
        expect_at(1, ecnt + LAT);
        tick(10);
        btn_up = 1'b0;
        tick(15);
        check("post_rst_mode", int'(mode_d), 1);

        tick(10);
        check("scoreboard_drained", exp_mode_q.size(), 0);
        check("final_mode", int'(mode_d), exp_mode);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
